// File: rtl/snake_dir_queue.sv
// Filters debounced direction presses against the newest pending heading and
// queues them, releasing at most one heading change per game-step tick.
module snake_dir_queue #(
  parameter int         DEPTH    = 4,
  parameter logic [1:0] INIT_DIR = 2'b01
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     press_up,
  input  logic                     press_right,
  input  logic                     press_down,
  input  logic                     press_left,
  input  logic                     tick,
  input  logic                     flush,
  output logic [1:0]               dir,
  output logic                     dir_chg,
  output logic                     rej,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [CW-1:0] ZERO_CNT = CW'(0);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);
  localparam logic [AW-1:0] ZERO_PTR = AW'(0);

  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [1:0]    r_dir;
  logic          r_dir_chg;
  logic          r_rej;
  logic          r_overflow;

  logic          w_any;
  logic [1:0]    w_cand;
  logic [1:0]    w_last;
  logic [AW-1:0] w_tail_idx;
  logic          w_pop;
  logic          w_filt_rej;
  logic          w_push;
  logic          w_ovf;

  // Candidate selection, filtering against the newest pending heading, push/pop decisions
  always_comb begin
    w_any      = press_up | press_right | press_down | press_left;
    w_cand     = 2'b00;
    w_tail_idx = r_wptr - ONE_PTR;
    if (press_up) begin
      w_cand = 2'b00;
    end else if (press_right) begin
      w_cand = 2'b01;
    end else if (press_down) begin
      w_cand = 2'b10;
    end else if (press_left) begin
      w_cand = 2'b11;
    end else begin
      w_cand = 2'b00;
    end
    if (r_count != ZERO_CNT) begin
      w_last = r_mem[w_tail_idx];
    end else begin
      w_last = r_dir;
    end
    w_pop      = tick && (r_count != ZERO_CNT);
    w_filt_rej = w_any && ((w_cand == w_last) || (w_cand == (w_last ^ 2'b10)));
    // A pop in the same cycle frees the slot, so a full queue still accepts
    w_push     = w_any && !w_filt_rej && ((r_count != FULL_CNT) || w_pop);
    w_ovf      = w_any && !w_filt_rej && (r_count == FULL_CNT) && !w_pop;
  end

  // Queue storage, pointers, heading and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 2'b00;
      end
      r_wptr     <= ZERO_PTR;
      r_rptr     <= ZERO_PTR;
      r_count    <= ZERO_CNT;
      r_dir      <= INIT_DIR;
      r_dir_chg  <= 1'b0;
      r_rej      <= 1'b0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wptr     <= ZERO_PTR;
      r_rptr     <= ZERO_PTR;
      r_count    <= ZERO_CNT;
      r_dir      <= INIT_DIR;
      r_dir_chg  <= 1'b0;
      r_rej      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_dir     <= r_mem[r_rptr];
        r_rptr    <= r_rptr + ONE_PTR;
        r_dir_chg <= 1'b1;
      end else begin
        r_dir_chg <= 1'b0;
      end
      if (w_push) begin
        r_mem[r_wptr] <= w_cand;
        r_wptr        <= r_wptr + ONE_PTR;
      end else begin
        r_wptr <= r_wptr;
      end
      if (w_ovf) begin
        r_overflow <= 1'b1;
      end else begin
        r_overflow <= r_overflow;
      end
      r_rej <= w_filt_rej;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dir      = r_dir;
  assign dir_chg  = r_dir_chg;
  assign rej      = r_rej;
  assign q_count  = r_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_snake_dir_queue.sv
// Self-checking bench for snake_dir_queue: a behavioural heading queue predicts
// every output; predictions are queued at drive time and compared after the edge.
module tb_snake_dir_queue;

  logic       clk;
  logic       rst_n;
  logic       press_up, press_right, press_down, press_left;
  logic       tick, flush;
  logic [1:0] dir;
  logic       dir_chg, rej, overflow;
  logic [2:0] q_count;

  int n_checks;
  int n_pass;

  typedef struct packed {
    logic [1:0] dir;
    logic       chg;
    logic       rej;
    logic [2:0] cnt;
    logic       ovf;
  } exp_t;

  exp_t       sb_q[$];
  logic [1:0] mq[$];
  logic [1:0] m_dir;
  logic       m_ovf;

  snake_dir_queue #(.DEPTH(4), .INIT_DIR(2'b01)) dut (
    .clk(clk), .rst_n(rst_n),
    .press_up(press_up), .press_right(press_right),
    .press_down(press_down), .press_left(press_left),
    .tick(tick), .flush(flush),
    .dir(dir), .dir_chg(dir_chg), .rej(rej),
    .q_count(q_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // One clock cycle of stimulus; the model predicts post-edge outputs from pre-edge state.
  task automatic step(input logic u, input logic r, input logic d, input logic l,
                      input logic t, input logic f);
    exp_t       e;
    exp_t       got;
    logic [1:0] cand;
    logic [1:0] last;
    logic       any;
    logic       rejc;
    logic       chg;
    @(negedge clk);
    press_up = u; press_right = r; press_down = d; press_left = l;
    tick = t; flush = f;
    any  = u | r | d | l;
    chg  = 1'b0;
    rejc = 1'b0;
    if (f) begin
      mq.delete();
      m_dir = 2'b01;
      m_ovf = 1'b0;
    end else begin
      cand = u ? 2'b00 : (r ? 2'b01 : (d ? 2'b10 : 2'b11));
      last = (mq.size() > 0) ? mq[mq.size()-1] : m_dir;
      if (t && mq.size() > 0) begin
        m_dir = mq.pop_front();
        chg   = 1'b1;
      end
      if (any) begin
        rejc = (cand == last) || (cand == (last ^ 2'b10));
        if (!rejc) begin
          if (mq.size() < 4) mq.push_back(cand);
          else m_ovf = 1'b1;
        end
      end
    end
    e.dir = m_dir; e.chg = chg; e.rej = rejc; e.cnt = 3'(mq.size()); e.ovf = m_ovf;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk("dir",      {6'd0, dir},      {6'd0, got.dir});
    chk("dir_chg",  {7'd0, dir_chg},  {7'd0, got.chg});
    chk("rej",      {7'd0, rej},      {7'd0, got.rej});
    chk("q_count",  {5'd0, q_count},  {5'd0, got.cnt});
    chk("overflow", {7'd0, overflow}, {7'd0, got.ovf});
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_dir"},      {6'd0, dir},      8'h01);
    chk({tag, "_dir_chg"},  {7'd0, dir_chg},  8'h00);
    chk({tag, "_rej"},      {7'd0, rej},      8'h00);
    chk({tag, "_q_count"},  {5'd0, q_count},  8'h00);
    chk({tag, "_overflow"}, {7'd0, overflow}, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0;
    press_up = 1'b0; press_right = 1'b0; press_down = 1'b0; press_left = 1'b0;
    tick = 1'b0; flush = 1'b0;
    m_dir = 2'b01; m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Press up, tick two cycles later, then a tick on an empty queue
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("up_applied", {6'd0, dir}, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Filter: reversal, repeat, then reversal of a queued entry
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rev_of_queued_cnt", {5'd0, q_count}, 8'h01);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Fill, overflow, then drain
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", {7'd0, overflow}, 8'h01);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Full queue with press and tick together
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("full_pushpop_cnt", {5'd0, q_count}, 8'h04);
    chk("full_pushpop_ovf", {7'd0, overflow}, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Simultaneous presses, press+tick on an empty queue, minimum latency
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Flush with a press in the same cycle
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_reset_vals("flush");

    // Asynchronous reset in mid-queue
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    mq.delete(); m_dir = 2'b01; m_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 60) == 0);
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/snake_dir_queue.md
Name: snake_dir_queue

Overview:
- Consumes the one-cycle press pulses produced by the per-button debouncers, one for each of the up, right, down and left buttons.
- Turns them into a filtered, buffered stream of snake heading changes.
- Releases at most one heading change per game-step strobe, so fast multi-key input such as "up then left" within one step is not lost.
- Sits between the four button debouncers and the snake movement/game-state logic.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- INIT_DIR, 2'b01, heading after reset or flush (right).

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- press_up  in  1  one-cycle press pulse from the debouncer.
- press_right  in  1  one-cycle press pulse.
- press_down  in  1  one-cycle press pulse.
- press_left  in  1  one-cycle press pulse.
- tick  in  1  one-cycle game-step strobe.
- flush  in  1  synchronous clear (game restart).
- dir  out  2  current heading: 00 up, 01 right, 10 down, 11 left.
- dir_chg  out  1  one-cycle pulse, high in the cycle dir takes a new value from the queue.
- rej  out  1  one-cycle pulse, a press was discarded by the filter.
- q_count  out  $clog2(DEPTH)+1  entries currently queued.
- overflow  out  1  sticky: a valid press was dropped because the queue was full.

Behaviour:
- Reset (rst_n low, asynchronous): dir=INIT_DIR, dir_chg=0, rej=0, q_count=0, overflow=0, queue pointers=0. Reset mid-operation discards all queued entries. Outputs are valid from the first edge after release.
- All outputs are registered.
- Candidate selection:
  - If any press input is high, candidate = highest priority asserted, with priority up > right > down > left.
  - Lower-priority simultaneous presses are ignored silently, with no rej.
- Reference heading:
  - last = newest queued entry (tail) if q_count>0, else dir.
  - Evaluated on pre-edge state.
- Filter: the candidate is rejected if candidate==last (repeat) or candidate==last^2'b10 (180° reversal). Rejection gives rej=1 for one cycle, registered one cycle after the press. Nothing is pushed.
- Push: an accepted candidate is written at the tail and q_count increments.
  - If the queue is full and no pop occurs that cycle, the candidate is dropped, overflow is set to 1, and rej stays 0.
  - overflow is cleared only by reset or flush.
- Pop: a cycle with tick=1 and q_count>0 gives, at the next edge, dir <= head entry, dir_chg=1 and q_count decrements.
  - tick with an empty queue: dir unchanged, dir_chg=0.
- Simultaneous push and pop in the same cycle:
  - Both happen and q_count is unchanged.
  - When full, the pop frees the slot, so the push succeeds with no overflow.
  - With q_count=1, last is the entry being popped; after the edge, dir = that entry and the queue holds the new one.
- Empty queue with press and tick together: no pop, the candidate is filtered against dir and pushed, and it is applied on the next tick.
- Latency: a press reaches dir no earlier than the edge after the first tick that follows its push. Minimum is a press in cycle N and tick in cycle N+1 giving dir updated at the end of N+1.
- flush=1 (highest priority over press/tick):
  - Next edge: queue emptied, q_count=0, dir=INIT_DIR, overflow=0, dir_chg=0, rej=0.
  - Presses in that cycle are discarded.
- Pointers are $clog2(DEPTH) bits and wrap naturally. q_count ranges 0..DEPTH.

Test Plan:
- Reset, then press_up, then tick two cycles later -> q_count 1 then 0; dir=00 with dir_chg pulse exactly one cycle; a second tick gives no dir_chg.
- From dir=01: press_left -> rej pulse, q_count stays 0; press_right -> rej pulse; press_down, then press_up before tick -> second press rejected as reversal of queued 10, q_count=1.
- From dir=01: presses up, left, down, right, up with no tick (DEPTH=4) -> q_count=4 after the fourth push, fifth press dropped, overflow=1; then 4 ticks -> dir sequence 00, 11, 10, 01, then dir_chg stays 0.
- Full queue, press and tick in the same cycle -> q_count stays 4, overflow stays 0, dir = head.
- press_up and press_left in the same cycle from dir=01 -> only 00 queued, no rej.
- Queue holding 2 entries, assert flush with a press that cycle -> q_count=0, dir=01, overflow=0. Repeat with rst_n low mid-queue -> immediate asynchronous clear to the same values.
